pc_fetch: RTL

Program-counter and instruction-fetch unit for the pipelined CPU. It owns the fetch PC, the instruction memory request/acknowledge handshake, a one-entry fetch buffer feeding decode, and the interrupt-enable/EPC state. It is the consumer of the `pc_sel`/`branch_sel` redirect codes that branch control produces for the instruction currently being decoded.

---
 rtl/pc_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Program-counter / instruction-fetch unit: one outstanding fetch, a one-entry
// buffer toward decode, and the interrupt-enable / EPC state.
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  branch_sel,
  input  logic [15:0] br_offset,
  input  logic [31:0] jr_target,
  input  logic [25:0] j_index,
  input  logic        eret,
  input  logic        int_req,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] epc,
  output logic        int_en1,
  output logic        int_pending
);

  typedef enum logic [1:0] {START, REQ, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_epc;
  logic        r_int_en1;

  logic        w_imem_req;
  logic        w_ack;
  logic        w_consume;
  logic [31:0] w_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_target;
  logic [31:0] w_epc_nxt;
  logic        w_int_en_nxt;

  assign w_pc4     = r_if_pc + 32'd4;
  assign w_ack     = (r_state == REQ) & imem_ack;
  assign w_consume = (r_state == HOLD) & r_if_valid & id_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= START;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_imem_req  = 1'b0;
    case (r_state)
      START: w_state_nxt = REQ;
      REQ: begin
        w_imem_req = 1'b1;
        if (imem_ack) w_state_nxt = HOLD;
      end
      HOLD:    if (w_consume) w_state_nxt = REQ;
      default: w_state_nxt = START;
    endcase
  end

  always_comb begin
    case (branch_sel)
      2'b00:   w_br_target = w_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};
      2'b01:   w_br_target = jr_target & ~32'd3;
      2'b10:   w_br_target = {w_pc4[31:28], j_index, 2'b00};
      default: w_br_target = w_pc4;
    endcase
  end

  // Redirect priority: reset vector, interrupt entry, eret, branch, sequential.
  always_comb begin
    w_target     = w_pc4;
    w_epc_nxt    = r_epc;
    w_int_en_nxt = r_int_en1;
    if (pc_sel == 2'b00) begin
      w_target     = RESET_VECTOR;
      w_int_en_nxt = 1'b0;
    end else if (pc_sel == 2'b01) begin
      w_target     = INT_VECTOR;
      w_epc_nxt    = r_if_pc;
      w_int_en_nxt = 1'b0;
    end else if (eret) begin
      w_target     = r_epc;
      w_int_en_nxt = 1'b1;
    end else if (pc_sel == 2'b11) begin
      w_target     = w_br_target;
    end
  end

  // Ack and consume are mutually exclusive: they live in different states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_VECTOR;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_epc      <= '0;
      r_int_en1  <= 1'b0;
    end else if (w_ack) begin
      r_if_instr <= imem_rdata;
      r_if_pc    <= r_fetch_pc;
      r_if_valid <= 1'b1;
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end else if (w_consume) begin
      r_if_valid <= 1'b0;
      r_fetch_pc <= w_target;
      r_epc      <= w_epc_nxt;
      r_int_en1  <= w_int_en_nxt;
    end
  end

  assign imem_req    = w_imem_req;
  assign imem_addr   = r_fetch_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign epc         = r_epc;
  assign int_en1     = r_int_en1;
  assign int_pending = int_req & r_int_en1;

endmodule
